// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } arb_state_t;

    localparam logic [2:0] MEM_CTRL_WORD = 3'b010;

    // Bits needed for a counter whose last value is cycles-1.
    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles < 3) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog for the outstanding memory transaction: counts wait cycles without an ack
// and flags expiry once the count reaches TIMEOUT_CYCLES-1.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned      CNT_W = timer_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign expired = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory port between instruction fetch and data access, one transaction
// in flight. Define MEM_ARB_FAIRNESS_EN to bound consecutive data grants while a fetch waits.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned size           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned MAX_D_STREAK   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [size-1:0] i_addr,
    output logic [size-1:0] i_rdata,
    output logic            i_valid,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [size-1:0] d_addr,
    input  logic [size-1:0] d_wdata,
    input  logic [2:0]      d_ctrl,
    output logic [size-1:0] d_rdata,
    output logic            d_valid,
    output logic            mem_req,
    output logic            mem_we,
    output logic [size-1:0] mem_addr,
    output logic [size-1:0] mem_wdata,
    output logic [2:0]      mem_ctrl,
    input  logic            mem_ack,
    input  logic [size-1:0] mem_rdata,
    output logic            stall_o,
    output logic            bus_error
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT_CYCLES must be at least 2");
    end
    if (MAX_D_STREAK < 1) begin : g_bad_streak
        $error("mem_port_arbiter: MAX_D_STREAK must be at least 1");
    end

    arb_state_t      state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [size-1:0] mem_addr_q, mem_addr_d;
    logic [size-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]      mem_ctrl_q, mem_ctrl_d;
    logic            bus_error_q, bus_error_d;

    logic in_wait;
    logic arb_now;
    logic abort;
    logic timer_expired;
    logic fetch_first;
    logic grant_d_sel;
    logic grant_i_sel;

    assign in_wait = (state_q == I_WAIT) || (state_q == D_WAIT);
    assign abort   = in_wait && timer_expired && !mem_ack;
    // Arbitration also happens in the ack cycle so back-to-back grants need no idle cycle.
    assign arb_now = (state_q == IDLE) || (in_wait && mem_ack);

    assign grant_d_sel = d_req && !fetch_first;
    assign grant_i_sel = i_req && !grant_d_sel;

    mem_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (arb_now || abort),
        .enable (in_wait && !mem_ack),
        .expired(timer_expired)
    );

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

    logic [STREAK_W-1:0] streak_q, streak_d;

    always_comb begin
        streak_d = streak_q;
        if (arb_now) begin
            if (!i_req || grant_i_sel) begin
                streak_d = '0;
            end else if (grant_d_sel) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign fetch_first = i_req && (streak_q == STREAK_W'(MAX_D_STREAK));
`else
    assign fetch_first = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_ctrl_d  = mem_ctrl_q;
        bus_error_d = bus_error_q;
        if (abort) begin
            state_d     = IDLE;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            bus_error_d = 1'b1;
        end else if (arb_now) begin
            if (grant_d_sel) begin
                state_d     = D_WAIT;
                mem_req_d   = 1'b1;
                mem_we_d    = d_we;
                mem_addr_d  = d_addr;
                mem_wdata_d = d_wdata;
                mem_ctrl_d  = d_ctrl;
            end else if (grant_i_sel) begin
                state_d     = I_WAIT;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b0;
                mem_addr_d  = i_addr;
                mem_wdata_d = '0;
                mem_ctrl_d  = MEM_CTRL_WORD;
            end else begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_ctrl_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_ctrl_q  <= mem_ctrl_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_ctrl  = mem_ctrl_q;
    assign bus_error = bus_error_q;

    // An aborted transaction still completes towards its owner, with zeroed data.
    assign i_valid = (state_q == I_WAIT) && (mem_ack || abort);
    assign d_valid = (state_q == D_WAIT) && (mem_ack || abort);
    assign i_rdata = abort ? '0 : mem_rdata;
    assign d_rdata = abort ? '0 : mem_rdata;

    assign stall_o = (i_req && !i_valid) || (d_req && !d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized traffic against
// a behavioural memory; expected completions are queued at issue and popped by a monitor.
module tb_mem_port_arbiter;

    localparam int unsigned TO_CYCLES = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_ctrl;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ctrl;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall_o;
    logic        bus_error;

    mem_port_arbiter #(
        .size          (32),
        .TIMEOUT_CYCLES(TO_CYCLES),
        .MAX_D_STREAK  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_valid  (i_valid),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ctrl   (d_ctrl),
        .d_rdata  (d_rdata),
        .d_valid  (d_valid),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ctrl (mem_ctrl),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .stall_o  (stall_o),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          chk;
    } exp_t;

    exp_t i_exp_q[$];
    exp_t d_exp_q[$];

    int checks   = 0;
    int failures = 0;
    int d_done_cnt = 0;

    // Memory behaviour: a non-word width code is folded into the stored/returned data so a
    // wrong mem_ctrl shows up as a data error.
    logic [31:0] mem_arr [bit [31:0]];
    logic [31:0] ref_mem [bit [31:0]];
    bit          hang       = 1'b0;
    bit          late_ack   = 1'b0;
    bit          rand_waits = 1'b0;
    int          fixed_wait = 0;

    function automatic logic [31:0] fold(input logic [2:0] c);
        return {c ^ 3'b010, 29'h0};
    endfunction

    function automatic logic [31:0] seed_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : seed_word(a);
    endfunction

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input bit is_d, input int budget, output int lat);
        lat = 0;
        while (1) begin
            next_cycle();
            lat++;
            if (is_d ? d_valid : i_valid) break;
            if (lat >= budget) begin
                checks++;
                failures++;
                $display("FAIL wait_%s no completion within %0d cycles", is_d ? "d" : "i", budget);
                break;
            end
        end
    endtask

    task automatic issue_fetch(input logic [31:0] addr, input bit expect_abort);
        exp_t e;
        i_req  = 1'b1;
        i_addr = addr;
        e.data = expect_abort ? 32'h0 : (ref_read(addr) ^ fold(3'b010));
        e.chk  = 1'b1;
        i_exp_q.push_back(e);
    endtask

    task automatic issue_data(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] ctrl);
        exp_t e;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        d_ctrl  = ctrl;
        if (we) begin
            ref_mem[addr] = wdata ^ fold(ctrl);
            e.data = 32'h0;
            e.chk  = 1'b0;
        end else begin
            e.data = ref_read(addr) ^ fold(ctrl);
            e.chk  = 1'b1;
        end
        d_exp_q.push_back(e);
    endtask

    // Memory slave: latches a transaction when mem_req appears, checks it stays stable, acks
    // after the chosen number of wait cycles.
    initial begin
        bit          busy;
        int          wait_left;
        logic [67:0] cap_bus;
        busy      = 1'b0;
        wait_left = 0;
        cap_bus   = '0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (reset) begin
                busy = 1'b0;
            end else if (late_ack) begin
                mem_ack  = 1'b1;
                late_ack = 1'b0;
            end else if (mem_req) begin
                if (!busy) begin
                    busy      = 1'b1;
                    cap_bus   = {mem_we, mem_ctrl, mem_addr, mem_wdata};
                    wait_left = rand_waits ? int'($urandom_range(0, 3)) : fixed_wait;
                end else begin
                    check("mem_stable", {mem_we, mem_ctrl, mem_addr, mem_wdata}, cap_bus);
                end
                if (!hang) begin
                    if (wait_left == 0) begin
                        mem_ack = 1'b1;
                        busy    = 1'b0;
                        if (mem_we) mem_arr[mem_addr] = mem_wdata ^ fold(mem_ctrl);
                        else        mem_rdata = mem_read(mem_addr) ^ fold(mem_ctrl);
                    end else begin
                        wait_left--;
                    end
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every completion pulse and checks the stall output.
    always @(negedge clk) begin
        if (!reset) begin
            if (i_valid) begin
                if (i_exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL i_valid_unexpected actual=1 required=0");
                end else begin
                    exp_t e;
                    e = i_exp_q.pop_front();
                    $display("txn port=I rdata=%h expected=%h", i_rdata, e.data);
                    check("i_rdata", i_rdata, e.data);
                end
            end
            if (d_valid) begin
                d_done_cnt++;
                if (d_exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL d_valid_unexpected actual=1 required=0");
                end else begin
                    exp_t e;
                    e = d_exp_q.pop_front();
                    $display("txn port=D we=%0d rdata=%h expected=%h", mem_we, d_rdata, e.data);
                    if (e.chk) check("d_rdata", d_rdata, e.data);
                end
            end
            check("stall_o", stall_o, (i_req && !i_valid) || (d_req && !d_valid));
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    int lat, lat2, d_base, d_before, exp_before;

    initial begin
        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        d_ctrl  = 3'b000;
        mem_arr[32'h100]  = 32'h0000_0013;
        ref_mem[32'h100]  = 32'h0000_0013;
        mem_arr[32'h2000] = 32'hDEAD_BEEF;
        ref_mem[32'h2000] = 32'hDEAD_BEEF;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_ctrl", mem_ctrl, 3'b000);
        check("rst_bus_error", bus_error, 1'b0);
        check("rst_stall", stall_o, 1'b0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Single fetch, 0-wait memory
        fixed_wait = 0;
        issue_fetch(32'h100, 1'b0);
        wait_done(1'b0, 20, lat);
        check("fetch_latency", lat, 1);
        i_req = 1'b0;
        next_cycle();
        @(negedge clk);
        check("fetch_req_dropped", mem_req, 1'b0);
        check("fetch_stall_low", stall_o, 1'b0);
        next_cycle();

        // Simultaneous requests: data first, fetch granted in the ack cycle
        issue_fetch(32'h104, 1'b0);
        issue_data(1'b0, 32'h2000, 32'h1111_2222, 3'b010);
        wait_done(1'b1, 20, lat);
        check("both_d_latency", lat, 1);
        d_req = 1'b0;
        wait_done(1'b0, 20, lat);
        check("both_i_latency", lat, 1);
        i_req = 1'b0;
        next_cycle();

        // Store with three wait cycles, then read it back
        fixed_wait = 3;
        issue_data(1'b1, 32'h40, 32'hA5A5_A5A5, 3'b000);
        wait_done(1'b1, 20, lat);
        check("store_latency", lat, 4);
        d_req = 1'b0;
        fixed_wait = 0;
        next_cycle();
        issue_data(1'b0, 32'h40, 32'h0, 3'b010);
        wait_done(1'b1, 20, lat);
        d_req = 1'b0;
        next_cycle();

        // Timeout on a fetch that is never acked
        hang = 1'b1;
        issue_fetch(32'h108, 1'b1);
        wait_done(1'b0, 20, lat);
        check("timeout_latency", lat, TO_CYCLES);
        i_req = 1'b0;
        hang  = 1'b0;
        next_cycle();
        @(negedge clk);
        check("timeout_bus_error", bus_error, 1'b1);
        check("timeout_req_dropped", mem_req, 1'b0);
        next_cycle();

        // Late ack after the abort is ignored
        late_ack = 1'b1;
        next_cycle();
        @(negedge clk);
        check("late_ack_i_valid", i_valid, 1'b0);
        check("late_ack_d_valid", d_valid, 1'b0);
        check("bus_error_sticky", bus_error, 1'b1);
        next_cycle();

        // Reset in the middle of a data transaction
        fixed_wait = 5;
        issue_data(1'b0, 32'h2004, 32'h7777_8888, 3'b100);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        d_req = 1'b0;
        d_exp_q.delete();
        #1;
        check("mid_rst_mem_req", mem_req, 1'b0);
        check("mid_rst_mem_addr", mem_addr, 32'h0);
        check("mid_rst_mem_wdata", mem_wdata, 32'h0);
        check("mid_rst_mem_ctrl", mem_ctrl, 3'b000);
        check("mid_rst_mem_we", mem_we, 1'b0);
        check("mid_rst_bus_error", bus_error, 1'b0);
        check("mid_rst_d_valid", d_valid, 1'b0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        fixed_wait = 0;
        next_cycle();
        issue_data(1'b0, 32'h2000, 32'h0, 3'b010);
        wait_done(1'b1, 20, lat);
        check("post_rst_latency", lat, 1);
        d_req = 1'b0;
        next_cycle();

        // Randomized concurrent traffic
        rand_waits = 1'b1;
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    if (gap != 0) begin
                        i_req = 1'b0;
                        repeat (gap) next_cycle();
                    end
                    issue_fetch(32'h1000 + 32'(4 * $urandom_range(0, 63)), 1'b0);
                    wait_done(1'b0, 300, lat);
                end
                i_req = 1'b0;
            end
            begin
                for (int n = 0; n < 60; n++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    if (gap != 0) begin
                        d_req = 1'b0;
                        repeat (gap) next_cycle();
                    end
                    issue_data(1'($urandom_range(0, 1)), 32'h2000 + 32'(4 * $urandom_range(0, 7)),
                               $urandom, 3'($urandom_range(0, 7)));
                    wait_done(1'b1, 300, lat2);
                end
                d_req = 1'b0;
            end
        join
        rand_waits = 1'b0;
        fixed_wait = 0;
        repeat (3) next_cycle();

        // Data held continuously while a fetch waits
`ifdef MEM_ARB_FAIRNESS_EN
        exp_before = 4;
`else
        exp_before = 6;
`endif
        d_base = d_done_cnt;
        issue_fetch(32'h1200, 1'b0);
        issue_data(1'b0, 32'h2008, $urandom, 3'b010);
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    wait_done(1'b1, 50, lat);
                    if (k < 5) issue_data(1'b0, 32'h2000 + 32'(4 * k), $urandom, 3'b010);
                    else       d_req = 1'b0;
                end
            end
            begin
                wait_done(1'b0, 100, lat2);
                d_before = d_done_cnt - d_base;
                i_req = 1'b0;
            end
        join
        check("d_grants_before_fetch", d_before, exp_before);
        repeat (4) next_cycle();

        @(negedge clk);
        check("i_queue_drained", i_exp_q.size(), 0);
        check("d_queue_drained", d_exp_q.size(), 0);
        check("final_idle_req", mem_req, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
